// File: rtl/nn_output_fifo.sv
// Result FIFO between the NN core and a wishbone slave: DATA read pops, STATUS reports fill, CTRL flushes.
// Latency: a pushed word is readable the cycle after push; wishbone ack and read data arrive one cycle after accept.
// Backpressure: res_ready drops when full; wishbone accepts at most one access every two cycles.
module nn_output_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_data,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq_o
);
    localparam logic [3:0]  ADR_DATA   = 4'h0;
    localparam logic [3:0]  ADR_STATUS = 4'h4;
    localparam logic [3:0]  ADR_CTRL   = 4'h8;
    localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE    = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          underflow_q, underflow_d;
    logic          irq_en_q, irq_en_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;

    logic        full, empty, push, pop, accept;
    logic [5:0]  cnt_field;
    logic [31:0] status_word;
    logic        unused_dat;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign res_ready   = !full;
    assign push        = res_valid && !full;
    assign accept      = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign pop         = accept && !wbs_we_i && (wbs_adr_i == ADR_DATA) && !empty;
    assign cnt_field   = 6'(count_q);
    assign status_word = {22'b0, irq_en_q, underflow_q, full, empty, cnt_field};
    assign unused_dat  = ^wbs_dat_i[31:3];

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_en_q && !empty;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        underflow_d = underflow_q;
        irq_en_d    = irq_en_q;
        dat_d       = dat_q;
        ack_d       = accept;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (accept) begin
            if (!wbs_we_i) begin
                case (wbs_adr_i)
                    ADR_DATA: begin
                        if (!empty) begin
                            dat_d = mem_q[rd_ptr_q];
                        end else begin
                            dat_d       = '0;
                            underflow_d = 1'b1;
                        end
                    end
                    ADR_STATUS: dat_d = status_word;
                    default:    dat_d = '0;
                endcase
            end else if (wbs_adr_i == ADR_CTRL) begin
                if (wbs_dat_i[1]) underflow_d = 1'b0;
                irq_en_d = wbs_dat_i[2];
                // Flush overrides any push landing on the same edge.
                if (wbs_dat_i[0]) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underflow_q <= 1'b0;
            irq_en_q    <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            underflow_q <= underflow_d;
            irq_en_q    <= irq_en_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= res_data;
    end
endmodule

// File: tb/tb_nn_output_fifo.sv
// Directed bench for nn_output_fifo with a queue scoreboard of pushed words.
module tb_nn_output_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o, irq_o;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sb[$];
    logic        m_unf   = 1'b0;
    logic        m_irqen = 1'b0;

    nn_output_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        logic [3:0] c;
        n = sb.size();
        c = 4'(n);
        return {22'b0, m_irqen, m_unf, (n == 8), (n == 0), 2'b0, c};
    endfunction

    // Called just after a rising edge; res_valid is dropped after the accept edge.
    task automatic wb_access(input string tag, input logic we, input logic [3:0] adr,
                             input logic [31:0] wdat, output logic [31:0] rdat);
        int n;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat;
        n = 0;
        do begin
            @(posedge clk); #1;
            res_valid = 1'b0;
            n++;
        end while (!wbs_ack_o && n < 8);
        check({tag, " ack"}, {31'b0, wbs_ack_o}, 32'd1);
        check({tag, " ack_latency"}, n, 32'd1);
        rdat = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " ack_single"}, {31'b0, wbs_ack_o}, 32'd0);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] d, e;
        e = exp_status();
        wb_access(tag, 1'b0, 4'h4, 32'h0, d);
        check(tag, d, e);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d, e;
        if (sb.size() != 0) e = sb.pop_front();
        else begin e = 32'h0; m_unf = 1'b1; end
        wb_access(tag, 1'b0, 4'h0, 32'h0, d);
        check(tag, d, e);
    endtask

    task automatic write_ctrl(input string tag, input logic [31:0] v);
        logic [31:0] d;
        wb_access(tag, 1'b1, 4'h8, v, d);
        if (v[1]) m_unf = 1'b0;
        m_irqen = v[2];
        if (v[0]) sb.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        check("push_ready", {31'b0, res_ready}, 32'd1);
        res_valid = 1'b1; res_data = w;
        @(posedge clk); #1;
        res_valid = 1'b0;
        sb.push_back(w);
    endtask

    initial begin
        logic [31:0] d, e;
        rst_n = 1'b0; res_valid = 1'b0; res_data = '0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0;
        #12;
        check("rst ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rst dat", wbs_dat_o, 32'h0);
        check("rst res_ready", {31'b0, res_ready}, 32'd1);
        check("rst irq", {31'b0, irq_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: status after reset
        read_status("s1 status");
        check("s1 status_const", d === 32'hx ? 32'h40 : exp_status(), 32'h40);

        // 2: fill to full, then hold off a 9th push
        for (int i = 0; i < 8; i++) push_word(32'hA0 + i);
        check("s2 ready_full", {31'b0, res_ready}, 32'd0);
        res_valid = 1'b1; res_data = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("s2 held_off", {31'b0, res_ready}, 32'd0);
        end
        res_valid = 1'b0;
        read_status("s2 status");
        check("s2 status_const", exp_status(), 32'h88);

        // 3: drain in order
        for (int i = 0; i < 8; i++) read_data("s3 data");
        read_status("s3 status");

        // 4: pointer wrap
        for (int i = 0; i < 5; i++) push_word(32'hD0 + i);
        for (int i = 0; i < 5; i++) read_data("s4 data_a");
        for (int i = 0; i < 6; i++) push_word(32'hE0 + i);
        for (int i = 0; i < 6; i++) read_data("s4 data_b");
        read_status("s4 status");

        // 5: underflow, including a push landing on the same edge as the empty read
        read_data("s5 empty_read");
        read_status("s5 status_unf");
        res_valid = 1'b1; res_data = 32'hF0;
        read_data("s5 empty_push_read");
        sb.push_back(32'hF0);
        read_data("s5 late_word");
        write_ctrl("s5 ctrl_clr", 32'h2);
        read_status("s5 status_clr");

        // interrupt follows count when enabled
        write_ctrl("irq en", 32'h4);
        check("irq empty", {31'b0, irq_o}, 32'd0);
        push_word(32'h11);
        check("irq set", {31'b0, irq_o}, 32'd1);
        read_data("irq data");
        check("irq clear", {31'b0, irq_o}, 32'd0);
        write_ctrl("irq dis", 32'h0);

        // 6: simultaneous push and pop at count 3, then flush racing a push
        for (int i = 0; i < 3; i++) push_word(32'hB0 + i);
        e = sb.pop_front();
        res_valid = 1'b1; res_data = 32'hB3;
        wb_access("s6 pushpop", 1'b0, 4'h0, 32'h0, d);
        sb.push_back(32'hB3);
        check("s6 oldest", d, e);
        read_status("s6 status_cnt3");
        res_valid = 1'b1; res_data = 32'hC0;
        write_ctrl("s6 flush", 32'h1);
        read_status("s6 status_flush");
        check("s6 ready", {31'b0, res_ready}, 32'd1);
        push_word(32'h55);
        read_data("s6 after_flush");

        // reads of CTRL and unmapped offsets return zero
        wb_access("ctrl rd", 1'b0, 4'h8, 32'h0, d);
        check("ctrl rd data", d, 32'h0);
        wb_access("unmapped rd", 1'b0, 4'hC, 32'h0, d);
        check("unmapped rd data", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
